// File: rtl/switch_fabric_hs.sv
// PORTS x PORTS crossbar with a one-entry output stage per port, all-or-nothing
// multicast handshaking and sticky per-output illegal-configuration flags.
module switch_fabric_hs #(
  parameter int WIDTH = 32,
  parameter int PORTS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS*WIDTH-1:0]   din,
  input  logic [PORTS-1:0]         din_valid,
  output logic [PORTS-1:0]         din_ready,
  input  logic [PORTS*PORTS-1:0]   cfg_vec,
  output logic [PORTS*WIDTH-1:0]   dout,
  output logic [PORTS-1:0]         dout_valid,
  input  logic [PORTS-1:0]         dout_ready,
  input  logic                     err_clr,
  output logic [PORTS-1:0]         cfg_err
);

  // sel_ok[o][i]: output o legally selects input i (illegal/idle slices select nothing)
  logic [PORTS-1:0][PORTS-1:0] sel_ok;
  logic [PORTS-1:0]            slice_illegal;
  logic [PORTS-1:0]            can_load;
  logic [PORTS-1:0]            din_ready_int;
  logic [PORTS-1:0]            xfer;

  logic [PORTS*WIDTH-1:0]      dout_q, dout_d;
  logic [PORTS-1:0]            dout_valid_q, dout_valid_d;
  logic [PORTS-1:0]            cfg_err_q, cfg_err_d;

  always_comb begin : slice_decode
    logic seen;
    logic multi;
    sel_ok        = '0;
    slice_illegal = '0;
    can_load      = '0;
    for (int o = 0; o < PORTS; o++) begin
      seen  = 1'b0;
      multi = 1'b0;
      // Gate-level one-hot test: a second set bit after any earlier one marks the slice illegal.
      for (int i = 0; i < PORTS; i++) begin
        multi = multi | (seen & cfg_vec[o*PORTS+i]);
        seen  = seen | cfg_vec[o*PORTS+i];
      end
      slice_illegal[o] = multi;
      sel_ok[o]        = (seen && !multi) ? cfg_vec[o*PORTS +: PORTS] : '0;
      can_load[o]      = !dout_valid_q[o] || dout_ready[o];
    end
  end

  always_comb begin : ready_gen
    logic has_sel;
    logic blocked;
    din_ready_int = '0;
    for (int i = 0; i < PORTS; i++) begin
      has_sel = 1'b0;
      blocked = 1'b0;
      for (int o = 0; o < PORTS; o++) begin
        has_sel = has_sel | sel_ok[o][i];
        blocked = blocked | (sel_ok[o][i] & !can_load[o]);
      end
      din_ready_int[i] = has_sel & !blocked & rst_n;
    end
  end

  assign xfer = din_valid & din_ready_int;

  always_comb begin : stage_next
    logic [WIDTH-1:0] word;
    logic             load;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    cfg_err_d    = '0;
    for (int o = 0; o < PORTS; o++) begin
      load = |(sel_ok[o] & xfer);
      word = '0;
      for (int i = 0; i < PORTS; i++) begin
        if (sel_ok[o][i]) begin
          word = word | din[i*WIDTH +: WIDTH];
        end
      end
      // Load wins over drain so a stage can pass one word per cycle without a bubble.
      if (load) begin
        dout_d[o*WIDTH +: WIDTH] = word;
        dout_valid_d[o]          = 1'b1;
      end else if (dout_valid_q[o] && dout_ready[o]) begin
        dout_valid_d[o] = 1'b0;
      end
      cfg_err_d[o] = slice_illegal[o] | (cfg_err_q[o] & !err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= '0;
      cfg_err_q    <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign din_ready  = din_ready_int;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_switch_fabric_hs.sv
// Scoreboard bench for switch_fabric_hs: per-output expected-word queues filled on
// input transfers and drained when an output handshake is observed.
module tb_switch_fabric_hs;
  localparam int P = 5;
  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [P*W-1:0]     din;
  logic [P-1:0]       din_valid;
  logic [P-1:0]       din_ready;
  logic [P*P-1:0]     cfg_vec;
  logic [P*W-1:0]     dout;
  logic [P-1:0]       dout_valid;
  logic [P-1:0]       dout_ready;
  logic               err_clr;
  logic [P-1:0]       cfg_err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [W-1:0] dw [P];
  logic [W-1:0] exp_q [P][$];
  logic [P-1:0] m_err;

  switch_fabric_hs #(.WIDTH(W), .PORTS(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .cfg_vec    (cfg_vec),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err_clr    (err_clr),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, update the model.
  task automatic step(input logic [P*P-1:0] c, input logic [P-1:0] vld,
                      input logic [P-1:0] rdy, input logic clr);
    logic [P-1:0] sel [P];
    logic [P-1:0] m_valid;
    logic [P-1:0] exp_rdy;
    logic [P-1:0] illegal;
    logic [P-1:0] s;
    logic         any;
    logic         ok;
    logic [W-1:0] w;
    @(negedge clk);
    for (int i = 0; i < P; i++) din[i*W +: W] = dw[i];
    cfg_vec    = c;
    din_valid  = vld;
    dout_ready = rdy;
    err_clr    = clr;
    #1;
    for (int o = 0; o < P; o++) begin
      s          = c[o*P +: P];
      illegal[o] = ($countones(s) > 1);
      sel[o]     = ($countones(s) == 1) ? s : '0;
      m_valid[o] = (exp_q[o].size() != 0);
    end
    for (int i = 0; i < P; i++) begin
      any = 1'b0;
      ok  = 1'b1;
      for (int o = 0; o < P; o++) begin
        if (sel[o][i]) begin
          any = 1'b1;
          if (m_valid[o] && !rdy[o]) ok = 1'b0;
        end
      end
      exp_rdy[i] = any && ok;
    end
    check_eq("dout_valid", dout_valid, m_valid);
    check_eq("cfg_err", cfg_err, m_err);
    check_eq("din_ready", din_ready, exp_rdy);
    for (int o = 0; o < P; o++) begin
      if (m_valid[o]) begin
        check_eq($sformatf("dout%0d", o), dout[o*W +: W], exp_q[o][0]);
        if (rdy[o]) begin
          w = exp_q[o].pop_front();
          $display("xfer out%0d data=%h", o, w);
        end
      end
    end
    for (int o = 0; o < P; o++)
      for (int i = 0; i < P; i++)
        if (sel[o][i] && vld[i] && exp_rdy[i]) exp_q[o].push_back(dw[i]);
    for (int o = 0; o < P; o++) m_err[o] = illegal[o] | (m_err[o] & !clr);
  endtask

  task automatic clear_model();
    for (int o = 0; o < P; o++) exp_q[o].delete();
    m_err = '0;
  endtask

  initial begin
    logic [P*P-1:0] c;
    logic [P*P-1:0] c_diag;
    logic [P-1:0]   s;
    int             vcnt;
    int             r;

    for (int i = 0; i < P; i++) dw[i] = 32'h1000_0000 + i;
    c_diag = '0;
    for (int o = 0; o < P; o++) c_diag[o*P+o] = 1'b1;
    clear_model();

    // Reset state with a legal config and valid inputs pending
    rst_n = 1'b0;
    for (int i = 0; i < P; i++) din[i*W +: W] = dw[i];
    din_valid = '1; dout_ready = '1; cfg_vec = c_diag; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_dout", dout[31:0] | dout[63:32] | dout[95:64] | dout[127:96] | dout[159:128], 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_din_ready", din_ready, 0);
    @(negedge clk);
    din_valid = '0;
    rst_n = 1'b1;

    // Unicast stream of 8 words input 0 -> output 2
    c = '0; c[14:10] = 5'b00001;
    vcnt = 0;
    for (int k = 0; k <= 8; k++) begin
      dw[0] = 32'hA5A5_0001 + k;
      step(c, (k < 8) ? 5'b00001 : 5'b00000, 5'b00100, 1'b0);
      if (k == 0) check_eq("uni_rdy0", din_ready[0], 1);
      if (k == 1) check_eq("uni_first", dout[2*W +: W], 32'hA5A5_0001);
      if (k >= 1 && dout_valid[2]) vcnt++;
    end
    check_eq("uni_valid_run", vcnt, 8);
    step(c, 5'b00000, 5'b00100, 1'b0);

    // Multicast stall: stage 3 already full and blocked
    c = '0; c[19:15] = 5'b00001;
    dw[0] = 32'h0000_0033;
    step(c, 5'b00001, 5'b00000, 1'b0);
    c = '0; c[9:5] = 5'b10000; c[19:15] = 5'b10000;
    dw[4] = 32'h0000_0044;
    step(c, 5'b10000, 5'b00000, 1'b0);
    check_eq("mc_stall_rdy4", din_ready[4], 0);
    step(c, 5'b10000, 5'b00000, 1'b0);
    check_eq("mc_stall_v1", dout_valid[1], 0);
    step(c, 5'b10000, 5'b01000, 1'b0);
    check_eq("mc_go_rdy4", din_ready[4], 1);
    step(c, 5'b00000, 5'b00000, 1'b0);
    check_eq("mc_out1", dout[1*W +: W], 32'h0000_0044);
    check_eq("mc_out3", dout[3*W +: W], 32'h0000_0044);
    step('0, 5'b00000, 5'b11111, 1'b0);
    step('0, 5'b00000, 5'b11111, 1'b0);

    // Illegal slice 0, then clear with the slice legal
    c = '0; c[4:0] = 5'b00110;
    dw[1] = 32'h0000_0011; dw[2] = 32'h0000_0022;
    step(c, 5'b00110, 5'b11111, 1'b0);
    check_eq("ill_rdy12", din_ready[2:1], 0);
    c[4:0] = 5'b00001;
    step(c, 5'b00000, 5'b11111, 1'b0);
    check_eq("ill_err0", cfg_err[0], 1);
    check_eq("ill_noload", dout_valid[0], 0);
    step(c, 5'b00000, 5'b11111, 1'b1);
    step(c, 5'b00000, 5'b11111, 1'b0);
    check_eq("ill_cleared", cfg_err[0], 0);

    // Reconfigure while output 4 is stalled
    c = '0; c[24:20] = 5'b00010;
    dw[1] = 32'hDEAD_BEEF;
    step(c, 5'b00010, 5'b00000, 1'b0);
    c[24:20] = 5'b00100;
    dw[2] = 32'h2222_2222;
    repeat (3) begin
      step(c, 5'b00100, 5'b00000, 1'b0);
      check_eq("rcfg_hold", dout[4*W +: W], 32'hDEAD_BEEF);
    end
    step(c, 5'b00100, 5'b10000, 1'b0);
    check_eq("rcfg_rdy2", din_ready[2], 1);
    step(c, 5'b00000, 5'b10000, 1'b0);
    check_eq("rcfg_new", dout[4*W +: W], 32'h2222_2222);

    // Asynchronous reset with every stage full and an error flag set
    for (int i = 0; i < P; i++) dw[i] = 32'hC0DE_0000 + i;
    step(c_diag, 5'b11111, 5'b00000, 1'b0);
    c = c_diag; c[4:0] = 5'b00011;
    step(c, 5'b00000, 5'b00000, 1'b0);
    step(c_diag, 5'b00000, 5'b00000, 1'b0);
    check_eq("pre_rst_valid", dout_valid, 5'b11111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", dout_valid, 0);
    check_eq("arst_err", cfg_err, 0);
    check_eq("arst_dout0", dout[0 +: W], 0);
    check_eq("arst_rdy", din_ready, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    c = '0; c[4:0] = 5'b00001;
    dw[0] = 32'h0BAD_F00D;
    step(c, 5'b00001, 5'b11111, 1'b0);
    step(c, 5'b00000, 5'b11111, 1'b0);
    check_eq("post_rst_out0", dout[0 +: W], 32'h0BAD_F00D);

    // Random legal / idle / illegal configurations with random handshakes
    for (int n = 0; n < 400; n++) begin
      c = '0;
      for (int o = 0; o < P; o++) begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          s = '0;
          s[$urandom_range(0, P-1)] = 1'b1;
        end else if (r < 8) begin
          s = '0;
        end else begin
          s = P'($urandom_range(0, 31));
        end
        c[o*P +: P] = s;
      end
      for (int i = 0; i < P; i++) dw[i] = $urandom;
      step(c, P'($urandom), P'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Drain and confirm nothing is left outstanding
    repeat (3) step('0, 5'b00000, 5'b11111, 1'b1);
    for (int o = 0; o < P; o++)
      check_eq($sformatf("left%0d", o), exp_q[o].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
